// File: rtl/upipe_pkg.sv
// Shared types and helpers for the elastic valid/ready pipeline.
// Provides the hold counter width, the per-stage state record and the occupancy width helper.
package upipe_pkg;

    localparam int unsigned HOLD_W = 4;

    typedef struct packed {
        logic              valid;
        logic [HOLD_W-1:0] hold;
    } stage_state_t;

    // Bits needed to count 0..depth inclusive.
    function automatic int unsigned clog2_p1(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_pipe_if.sv
// Valid/ready token channel between elastic pipeline stages and their neighbours.
// The master drives valid and data; the slave drives ready.
interface elastic_pipe_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/elastic_stage.sv
// One elastic stage: valid/hold/data registers, ripeness and its link of the ready chain.
// A stage may take a new token in the same cycle it hands its own ripe token downstream.
module elastic_stage
    import upipe_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FUN_DELAY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_up_valid,
    input  logic [WIDTH-1:0] i_up_data,
    input  logic             i_dn_acc,
    output logic             o_acc_out,
    output logic             o_ripe,
    output logic [WIDTH-1:0] o_data
);

    stage_state_t     r_state;
    logic [WIDTH-1:0] r_data;
    logic             w_load;
    logic             w_hand;

    assign o_ripe    = r_state.valid & (r_state.hold == '0);
    assign o_acc_out = ~r_state.valid | (o_ripe & i_dn_acc);
    assign w_load    = o_acc_out & i_up_valid;
    assign w_hand    = o_ripe & i_dn_acc;
    assign o_data    = r_data;

    // Flush drops tokens but leaves the data register untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= '0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_state <= '0;
        end else if (w_load) begin
            r_state.valid <= 1'b1;
            r_state.hold  <= HOLD_W'(FUN_DELAY);
            r_data        <= i_up_data;
        end else if (w_hand) begin
            r_state.valid <= 1'b0;
        end else if (r_state.valid && (r_state.hold != '0)) begin
            r_state.hold <= r_state.hold - HOLD_W'(1);
        end
    end

endmodule

// File: rtl/elastic_pipe.sv
// DEPTH-stage elastic valid/ready pipeline with per-stage function delay, go gating,
// synchronous flush and an occupancy counter.
module elastic_pipe
    import upipe_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned FUN_DELAY = 0,
    localparam int unsigned OCC_W    = clog2_p1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go_l,
    input  logic             go_r,
    input  logic             flush,
    elastic_pipe_if.slave    in_if,
    elastic_pipe_if.master   out_if,
    output logic [OCC_W-1:0] occupancy
);

    logic             w_acc_last;
    logic             w_in_ready;
    logic             w_in_acc;
    logic             w_out_valid;
    logic             w_out_acc;
    logic [OCC_W-1:0] r_occ;

    // Stage chain; acceptance ripples right to left, tokens move left to right.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             w_up_valid;
        logic [WIDTH-1:0] w_up_data;
        logic             w_dn_acc;
        logic             w_acc;
        logic             w_ripe;
        logic [WIDTH-1:0] w_data;

        if (i == 0) begin : g_head
            assign w_up_valid = w_in_acc;
            assign w_up_data  = in_if.data;
        end else begin : g_body
            assign w_up_valid = g_stage[i-1].w_ripe;
            assign w_up_data  = g_stage[i-1].w_data;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign w_dn_acc = w_acc_last;
        end else begin : g_link
            assign w_dn_acc = g_stage[i+1].w_acc;
        end

        elastic_stage #(
            .WIDTH     (WIDTH),
            .FUN_DELAY (FUN_DELAY)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_flush    (flush),
            .i_up_valid (w_up_valid),
            .i_up_data  (w_up_data),
            .i_dn_acc   (w_dn_acc),
            .o_acc_out  (w_acc),
            .o_ripe     (w_ripe),
            .o_data     (w_data)
        );
    end

    assign w_acc_last  = out_if.ready & go_r;
    assign w_in_ready  = g_stage[0].w_acc & go_l & rst_n & ~flush;
    assign w_in_acc    = in_if.valid & w_in_ready;
    // Reset masks the output so a mid-run reset never shows a token.
    assign w_out_valid = g_stage[DEPTH-1].w_ripe & go_r & rst_n;
    assign w_out_acc   = w_out_valid & out_if.ready;

    assign in_if.ready  = w_in_ready;
    assign out_if.valid = w_out_valid;
    assign out_if.data  = g_stage[DEPTH-1].w_data;
    assign occupancy    = r_occ;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_occ <= '0;
        end else if (w_in_acc && !w_out_acc) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (!w_in_acc && w_out_acc) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_elastic_pipe.sv
// Scoreboard bench for elastic_pipe: two instances (FUN_DELAY 0 and 2) share control inputs,
// each fed by its own token source and checked against a queue model of tokens in flight.
module tb_elastic_pipe;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] data;
        int unsigned cyc;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, go_l, go_r, flush, out_ready, chk_exact;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    elastic_pipe_if #(.WIDTH(W)) in0 ();
    elastic_pipe_if #(.WIDTH(W)) out0 ();
    elastic_pipe_if #(.WIDTH(W)) in1 ();
    elastic_pipe_if #(.WIDTH(W)) out1 ();
    logic [OCC_W-1:0] occ0, occ1;

    elastic_pipe #(.WIDTH(W), .DEPTH(DEPTH), .FUN_DELAY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .go_l(go_l), .go_r(go_r), .flush(flush),
        .in_if(in0), .out_if(out0), .occupancy(occ0)
    );
    elastic_pipe #(.WIDTH(W), .DEPTH(DEPTH), .FUN_DELAY(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .go_l(go_l), .go_r(go_r), .flush(flush),
        .in_if(in1), .out_if(out1), .occupancy(occ1)
    );

    logic             src_v [2];
    logic [31:0]      src_d [2];
    logic             in_r  [2];
    logic             out_v [2];
    logic [31:0]      out_d [2];
    logic [OCC_W-1:0] occ   [2];

    assign in0.valid  = src_v[0];
    assign in0.data   = src_d[0];
    assign in1.valid  = src_v[1];
    assign in1.data   = src_d[1];
    assign out0.ready = out_ready;
    assign out1.ready = out_ready;
    assign in_r[0]  = in0.ready;
    assign in_r[1]  = in1.ready;
    assign out_v[0] = out0.valid;
    assign out_v[1] = out1.valid;
    assign out_d[0] = out0.data;
    assign out_d[1] = out1.data;
    assign occ[0]   = occ0;
    assign occ[1]   = occ1;

    logic [31:0] src_q [2][$];
    sb_t         sb_q  [2][$];
    int          acc_hist [2][$];
    int          n_out [2];
    int          last_lat [2];
    logic [31:0] last_dat [2];
    int          n_chk = 0;
    int          n_pass = 0;

    // Unstalled latency: DEPTH stages, each held 1+FUN_DELAY cycles.
    function automatic int lat_of(input int d);
        return (d == 0) ? DEPTH * 1 : DEPTH * 3;
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic check_ge(input string name, input longint got, input longint minv);
        n_chk++;
        if (got >= minv) n_pass++;
        else $display("FAIL %s: got %0d expected at least %0d (t=%0t)", name, got, minv, $time);
    endtask

    // Token sources: present the head of each queue, pop it once accepted.
    initial begin
        logic took [2];
        for (int d = 0; d < 2; d++) begin
            src_v[d] = 1'b0;
            src_d[d] = $urandom;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            if (src_q[d].size() > 0) begin
                src_v[d] = 1'b1;
                src_d[d] = src_q[d][0];
            end
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) took[d] = src_v[d] & in_r[d];
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (took[d]) void'(src_q[d].pop_front());
                if (src_q[d].size() > 0) begin
                    src_v[d] = 1'b1;
                    src_d[d] = src_q[d][0];
                end else begin
                    src_v[d] = 1'b0;
                    src_d[d] = $urandom;
                end
            end
        end
    end

    // Monitor: compares handshakes and occupancy against the in-flight queue.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                sb_t e;
                int  sz;
                int  lat;
                sz = sb_q[d].size();
                check($sformatf("occupancy[%0d]", d), occ[d], sz);
                if (!rst_n || flush || !go_l)
                    check($sformatf("in_ready_blocked[%0d]", d), in_r[d], 0);
                else if (sz == 0)
                    check($sformatf("in_ready_empty[%0d]", d), in_r[d], 1);
                else if (sz == DEPTH && !(out_v[d] && out_ready))
                    check($sformatf("in_ready_full[%0d]", d), in_r[d], 0);
                if (!rst_n || !go_r || sz == 0)
                    check($sformatf("out_valid_idle[%0d]", d), out_v[d], 0);
                if (out_v[d] && out_ready && rst_n) begin
                    if (sz == 0) begin
                        check($sformatf("unexpected_out[%0d]", d), out_d[d], 0);
                    end else begin
                        e   = sb_q[d].pop_front();
                        lat = cyc - int'(e.cyc);
                        check($sformatf("out_data[%0d]", d), out_d[d], e.data);
                        if (chk_exact) check($sformatf("latency[%0d]", d), lat, lat_of(d));
                        else check_ge($sformatf("latency_min[%0d]", d), lat, lat_of(d));
                        last_lat[d] = lat;
                        last_dat[d] = out_d[d];
                        n_out[d]++;
                    end
                end
                if (src_v[d] && in_r[d]) begin
                    e.data = src_d[d];
                    e.cyc  = cyc;
                    sb_q[d].push_back(e);
                    acc_hist[d].push_back(cyc);
                end
                if (!rst_n || flush) sb_q[d].delete();
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_both(input logic [31:0] v);
        src_q[0].push_back(v);
        src_q[1].push_back(v);
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (!(src_q[0].size() == 0 && src_q[1].size() == 0 &&
                 sb_q[0].size() == 0 && sb_q[1].size() == 0) && n < 2000) begin
            tick(1);
            n++;
        end
        check({tag, "_drain_timeout"}, (n < 2000) ? 1 : 0, 1);
    endtask

    initial begin
        int rel_cyc;
        int base [2];
        rst_n = 1'b0; go_l = 1'b1; go_r = 1'b1; flush = 1'b0; out_ready = 1'b1; chk_exact = 1'b1;
        for (int d = 0; d < 2; d++) begin
            n_out[d] = 0;
            last_lat[d] = 0;
            last_dat[d] = '0;
        end
        for (int v = 1; v <= 8; v++) push_both(32'(v));

        // Reset held two edges with tokens waiting, then streaming 1..8.
        tick(1);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_in_ready[%0d]", d), in_r[d], 0);
            check($sformatf("rst_out_valid[%0d]", d), out_v[d], 0);
            check($sformatf("rst_occ[%0d]", d), occ[d], 0);
            check($sformatf("rst_out_data[%0d]", d), out_d[d], 0);
        end
        tick(1);
        check("rst_in_valid_offered", src_v[0], 1);
        rel_cyc = cyc;
        rst_n = 1'b1;
        wait_empty("stream");
        for (int d = 0; d < 2; d++) begin
            check($sformatf("first_accept_cycle[%0d]", d), acc_hist[d][0], rel_cyc);
            check($sformatf("stream_count[%0d]", d), n_out[d], 8);
            for (int k = 1; k < 8; k++)
                check($sformatf("accept_period[%0d]", d), acc_hist[d][k] - acc_hist[d][k-1],
                      (d == 0) ? 1 : 3);
        end

        // Lone token through an empty pipe.
        push_both(32'hA5);
        wait_empty("single");
        for (int d = 0; d < 2; d++) begin
            check($sformatf("single_data[%0d]", d), last_dat[d], 32'hA5);
            check($sformatf("single_latency[%0d]", d), last_lat[d], lat_of(d));
        end
        chk_exact = 1'b0;

        // Backpressure: six offered, four fit.
        out_ready = 1'b0;
        for (int v = 0; v < 6; v++) push_both(32'h100 + 32'(v));
        tick(40);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("bp_occ[%0d]", d), occ[d], 4);
            check($sformatf("bp_in_ready[%0d]", d), in_r[d], 0);
            check($sformatf("bp_left[%0d]", d), src_q[d].size(), 2);
        end
        out_ready = 1'b1;
        wait_empty("backpressure");

        // go_r pause holds two tokens.
        for (int d = 0; d < 2; d++) base[d] = n_out[d];
        go_r = 1'b0;
        push_both(32'h11);
        push_both(32'h22);
        tick(40);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("gor_out_valid[%0d]", d), out_v[d], 0);
            check($sformatf("gor_out_data[%0d]", d), out_d[d], 32'h11);
            check($sformatf("gor_occ[%0d]", d), occ[d], 2);
        end
        go_r = 1'b1;
        wait_empty("go_r");
        for (int d = 0; d < 2; d++) check($sformatf("gor_emerged[%0d]", d), n_out[d] - base[d], 2);

        // go_l pause while the pipe drains.
        out_ready = 1'b0;
        for (int v = 0; v < 3; v++) push_both(32'h200 + 32'(v));
        tick(30);
        go_l = 1'b0;
        out_ready = 1'b1;
        push_both(32'h300);
        push_both(32'h301);
        tick(60);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("gol_drained_occ[%0d]", d), occ[d], 0);
            check($sformatf("gol_in_ready[%0d]", d), in_r[d], 0);
            check($sformatf("gol_not_taken[%0d]", d), src_q[d].size(), 2);
        end
        go_l = 1'b1;
        wait_empty("go_l");

        // Flush with three inside and a token offered.
        out_ready = 1'b0;
        for (int v = 0; v < 3; v++) push_both(32'h31 + 32'(v));
        tick(40);
        push_both(32'h44);
        tick(1);
        for (int d = 0; d < 2; d++) check($sformatf("fl_pre_occ[%0d]", d), occ[d], 3);
        flush = 1'b1;
        tick(1);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("fl_occ[%0d]", d), occ[d], 0);
            check($sformatf("fl_out_valid[%0d]", d), out_v[d], 0);
            check($sformatf("fl_not_taken[%0d]", d), src_q[d].size(), 1);
        end
        flush = 1'b0;
        out_ready = 1'b1;
        wait_empty("flush");

        // Full pipe: accept in and out in the same cycle.
        out_ready = 1'b0;
        for (int v = 0; v < 5; v++) push_both(32'h51 + 32'(v));
        tick(40);
        for (int d = 0; d < 2; d++) check($sformatf("full_occ[%0d]", d), occ[d], 4);
        out_ready = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("full_in_ready[%0d]", d), in_r[d], 1);
            check($sformatf("full_out_valid[%0d]", d), out_v[d], 1);
        end
        tick(1);
        for (int d = 0; d < 2; d++) check($sformatf("simul_occ[%0d]", d), occ[d], 4);
        wait_empty("simul");

        // Randomised traffic.
        for (int k = 0; k < 800; k++) begin
            go_l      = ($urandom % 8) != 0;
            go_r      = ($urandom % 8) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 50) == 0;
            if (src_q[0].size() < 3 && $urandom % 2 == 1) src_q[0].push_back($urandom);
            if (src_q[1].size() < 3 && $urandom % 2 == 1) src_q[1].push_back($urandom);
            tick(1);
        end
        go_l = 1'b1; go_r = 1'b1; flush = 1'b0; out_ready = 1'b1;
        wait_empty("random");

        // Reset mid-operation drops everything without an output pulse.
        out_ready = 1'b0;
        for (int v = 0; v < 3; v++) push_both(32'h71 + 32'(v));
        tick(30);
        for (int d = 0; d < 2; d++) base[d] = n_out[d];
        rst_n = 1'b0;
        out_ready = 1'b1;
        tick(2);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("mid_rst_occ[%0d]", d), occ[d], 0);
            check($sformatf("mid_rst_out_valid[%0d]", d), out_v[d], 0);
        end
        rst_n = 1'b1;
        tick(20);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("mid_rst_no_out[%0d]", d), n_out[d] - base[d], 0);
            check($sformatf("mid_rst_empty[%0d]", d), occ[d], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
